// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch unit: FSM states and buffer entry layout.
package fetch_pkg;

  typedef enum logic [1:0] {
    StFetch,
    StFlush,
    StHalt
  } state_e;

  // One buffered fetch result; err marks an entry produced by a bus error response.
  typedef struct packed {
    logic        err;
    logic [31:0] pc;
    logic [31:0] data;
  } entry_t;

  localparam int unsigned EntryWidth = $bits(entry_t);

  // Word-address increment; wraps from all-ones to zero.
  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return pc + 32'd1;
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Pipelined read-only bus between the fetch unit (master) and instruction memory (slave).
interface fetch_if;
  logic [31:0] bus_data_s;
  logic        bus_ack;
  logic        bus_stall;
  logic        bus_err;
  logic [31:0] bus_data_m;
  logic [31:0] bus_addr;
  logic [3:0]  bus_sel;
  logic        bus_cyc;
  logic        bus_stb;
  logic        bus_we;

  modport master (
    input  bus_data_s, bus_ack, bus_stall, bus_err,
    output bus_data_m, bus_addr, bus_sel, bus_cyc, bus_stb, bus_we
  );

  modport slave (
    output bus_data_s, bus_ack, bus_stall, bus_err,
    input  bus_data_m, bus_addr, bus_sel, bus_cyc, bus_stb, bus_we
  );
endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with occupancy count and single-cycle flush; Depth must be a power of two.
module sync_fifo #(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [Width-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [Width-1:0]           rdata_o,
  output logic [$clog2(Depth):0]     count_o,
  output logic                       empty_o
);

  localparam int unsigned AddrW = $clog2(Depth);
  localparam int unsigned CntW  = AddrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AddrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             full;
  logic             do_push, do_pop;

  // Occupancy flags, accepted push/pop and next pointer/count values.
  always_comb begin
    full     = (count_q == CntW'(Depth));
    empty_o  = (count_q == '0);
    count_o  = count_q;
    rdata_o  = mem_q[rd_ptr_q];
    // A push into a full FIFO is allowed when the head leaves in the same cycle.
    do_push  = push_i && (!full || pop_i);
    do_pop   = pop_i && !empty_o;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AddrW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AddrW'(1);
      count_d = count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are meaningless while empty so it needs no reset.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues sequential word fetches on a pipelined bus, buffers
// responses in order, and supports redirect (restart) and halt-on-error.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] ResetVector = 32'h0000_0000,
  parameter int unsigned FifoDepth   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  fetch_if.master     bus,
  output logic        instr_valid,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc,
  output logic        instr_err,
  input  logic        instr_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  localparam int unsigned CntW = $clog2(FifoDepth) + 1;

  state_e          state_q, state_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [31:0]     resp_pc_q, resp_pc_d;
  logic [CntW-1:0] outst_q, outst_d;

  logic [CntW-1:0] fifo_count;
  logic            fifo_empty;
  logic [EntryWidth-1:0] head_bits;
  entry_t          head;
  entry_t          push_entry;
  logic [CntW:0]   inflight;
  logic            credit_ok;
  logic            resp_valid;
  logic            stb, cyc;
  logic            issue, push, pop;

  // Bus request generation, response qualification and buffer control.
  always_comb begin
    // Outstanding is zero whenever bus_cyc is low, so this also drops stray responses.
    resp_valid = (bus.bus_ack || bus.bus_err) && (outst_q != '0);
    inflight   = {1'b0, outst_q} + {1'b0, fifo_count};
    credit_ok  = inflight < (CntW + 1)'(FifoDepth);
    // Gated by rst_n so no strobe appears while reset is held; an error response
    // suppresses the request in the same cycle so nothing is fetched past it.
    stb        = rst_n && (state_q == StFetch) && credit_ok && !(resp_valid && bus.bus_err);
    cyc        = 1'b0;
    case (state_q)
      StFetch: cyc = stb || (outst_q != '0);
      StHalt:  cyc = (outst_q != '0);
      default: cyc = 1'b0;
    endcase
    issue       = stb && !bus.bus_stall;
    push        = resp_valid && !redirect_valid;
    instr_valid = !fifo_empty;
    pop         = instr_valid && instr_ready && !redirect_valid;
    push_entry  = '{err: bus.bus_err, pc: resp_pc_q, data: bus.bus_data_s};
    head        = entry_t'(head_bits);
    instr_data  = head.data;
    instr_pc    = head.pc;
    instr_err   = instr_valid && head.err;
  end

  assign bus.bus_stb    = stb;
  assign bus.bus_cyc    = cyc;
  assign bus.bus_addr   = fetch_pc_q;
  assign bus.bus_data_m = '0;
  assign bus.bus_sel    = 4'hF;
  assign bus.bus_we     = 1'b0;

  // Next state, fetch/response pointers and outstanding-request count.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    outst_d    = outst_q;
    if (redirect_valid) begin
      // Redirect overrides everything, including a coincident response or pop.
      state_d    = StFlush;
      fetch_pc_d = redirect_pc;
      resp_pc_d  = redirect_pc;
      outst_d    = '0;
    end else begin
      case (state_q)
        StFetch: if (resp_valid && bus.bus_err) state_d = StHalt;
        StFlush: state_d = StFetch;
        StHalt:  state_d = StHalt;
        default: state_d = StFetch;
      endcase
      if (issue)      fetch_pc_d = pc_inc(fetch_pc_q);
      if (resp_valid) resp_pc_d  = pc_inc(resp_pc_q);
      outst_d = outst_q + CntW'(issue) - CntW'(resp_valid);
    end
  end

  // State and pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StFetch;
      fetch_pc_q <= ResetVector;
      resp_pc_q  <= ResetVector;
      outst_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      outst_q    <= outst_d;
    end
  end

  sync_fifo #(
    .Width (EntryWidth),
    .Depth (FifoDepth)
  ) u_buf (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .flush_i (redirect_valid),
    .push_i  (push),
    .wdata_i (push_entry),
    .pop_i   (pop),
    .rdata_o (head_bits),
    .count_o (fifo_count),
    .empty_o (fifo_empty)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, error/halt sequence, and a randomized run
// against a queue-based reference model with a latency-randomizing bus slave.
module tb_fetch_unit;

  localparam logic [31:0] ResetVec = 32'h0000_0000;
  localparam int          Depth    = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid, instr_err, instr_ready, redirect_valid;
  logic [31:0] instr_data, instr_pc, redirect_pc;

  always #5 clk = ~clk;

  fetch_if bus ();

  fetch_unit #(
    .ResetVector (ResetVec),
    .FifoDepth   (Depth)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .instr_valid    (instr_valid),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc),
    .instr_err      (instr_err),
    .instr_ready    (instr_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  // Bus slave: in-order responses, each after a random latency from acceptance.
  typedef struct {
    logic [31:0] addr;
    int          ready_at;
    bit          err;
  } req_t;
  req_t        sq[$];
  int          cyc_no = 0;
  int          lat_lo = 1, lat_hi = 1, err_pct = 0;
  bit          err_on = 1'b0;
  logic [31:0] err_addr = '0;

  // Reference model: buffer as a queue, counts as integers.
  typedef struct {
    bit          err;
    logic [31:0] pc;
    logic [31:0] data;
  } ment_t;
  ment_t       mq[$];
  int          m_out;
  bit          m_flush, m_halt;
  logic [31:0] m_fpc, m_rpc;

  bit          cur_resp, cur_err, cur_stl, cur_rdy, cur_rdr;
  logic [31:0] cur_data, cur_rpc;

  task automatic model_reset();
    mq.delete();
    sq.delete();
    m_out = 0; m_flush = 0; m_halt = 0;
    m_fpc = ResetVec; m_rpc = ResetVec;
  endtask

  task automatic idle_inputs();
    bus.bus_ack = 0; bus.bus_err = 0; bus.bus_stall = 0; bus.bus_data_s = '0;
    instr_ready = 0; redirect_valid = 0; redirect_pc = '0;
  endtask

  // Drive one cycle's inputs at the falling edge and let combinational outputs settle.
  task automatic t_drive(input bit rdy, input bit stl, input bit rdr, input logic [31:0] rpc);
    @(negedge clk);
    cur_resp = (sq.size() > 0) && (sq[0].ready_at <= cyc_no);
    cur_err  = cur_resp && sq[0].err;
    cur_data = cur_resp ? word_of(sq[0].addr) : 32'hDEAD_BEEF;
    cur_stl = stl; cur_rdy = rdy; cur_rdr = rdr; cur_rpc = rpc;
    bus.bus_ack = cur_resp && !cur_err; bus.bus_err = cur_err;
    bus.bus_data_s = cur_data; bus.bus_stall = stl;
    instr_ready = rdy; redirect_valid = rdr; redirect_pc = rpc;
    #1;
  endtask

  // Compare against the model, then advance model and slave to the next cycle.
  task automatic t_finish();
    bit here, e_stb, e_cyc;
    int lat;
    here  = cur_resp && (m_out > 0) && !m_flush;
    e_stb = !m_flush && !m_halt && (m_out + mq.size() < Depth) && !(here && cur_err);
    e_cyc = !m_flush && (e_stb || m_out > 0);
    chk("m_stb", bus.bus_stb, e_stb);
    chk("m_cyc", bus.bus_cyc, e_cyc);
    if (e_stb) chk("m_addr", bus.bus_addr, m_fpc);
    chk("m_valid", instr_valid, mq.size() > 0);
    if (mq.size() > 0) begin
      chk("m_pc", instr_pc, mq[0].pc);
      chk("m_data", instr_data, mq[0].data);
      chk("m_err", instr_err, mq[0].err);
    end
    if (cur_rdr) begin
      mq.delete(); m_out = 0; m_fpc = cur_rpc; m_rpc = cur_rpc; m_flush = 1; m_halt = 0;
    end else begin
      m_flush = 0;
      if (mq.size() > 0 && cur_rdy) void'(mq.pop_front());
      if (here) begin
        mq.push_back('{cur_err, m_rpc, cur_data});
        m_rpc = m_rpc + 32'd1;
        m_out--;
        if (cur_err) m_halt = 1;
      end
      if (e_stb && !cur_stl) begin
        m_out++;
        m_fpc = m_fpc + 32'd1;
      end
    end
    if (cur_resp) void'(sq.pop_front());
    if (bus.bus_cyc !== 1'b1) sq.delete();
    else if (bus.bus_stb === 1'b1 && !cur_stl) begin
      lat = $urandom_range(lat_hi, lat_lo);
      sq.push_back('{bus.bus_addr, cyc_no + lat,
                     (err_on && bus.bus_addr == err_addr) || ($urandom_range(99, 0) < err_pct)});
    end
    cyc_no++;
  endtask

  task automatic tick(input bit rdy, input bit stl, input bit rdr, input logic [31:0] rpc);
    t_drive(rdy, stl, rdr, rpc);
    t_finish();
  endtask

  // Assert reset for n cycles, check reset outputs, release just after a rising edge.
  task automatic do_reset(input int n);
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    #1;
    chk("rst_stb", bus.bus_stb, 0);
    chk("rst_cyc", bus.bus_cyc, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_err", instr_err, 0);
    chk("rst_we", bus.bus_we, 0);
    chk("rst_sel", bus.bus_sel, 4'hF);
    chk("rst_data_m", bus.bus_data_m, 0);
    repeat (n) @(posedge clk);
    model_reset();
    #1 rst_n = 1'b1;
  endtask

  typedef struct {
    bit          rdy, stl, rdr;
    logic [31:0] rpc;
    bit          e_stb, e_cyc;
    logic [31:0] e_addr;
    bit          e_valid;
    logic [31:0] e_pc;
  } vec_t;
  vec_t tbl[19];

  initial begin
    int past7, seen_err;
    logic [31:0] err_pc;

    // Cycle-by-cycle from reset release, 1-cycle acks: fill to 4 with ready low, drain,
    // stall on address 5, then redirect to 0x100 coincident with an ack and a pop.
    tbl[0]  = '{0, 0, 0, 0,      1, 1, 32'h0,   0, 0};
    tbl[1]  = '{0, 0, 0, 0,      1, 1, 32'h1,   0, 0};
    tbl[2]  = '{0, 0, 0, 0,      1, 1, 32'h2,   1, 32'h0};
    tbl[3]  = '{0, 0, 0, 0,      1, 1, 32'h3,   1, 32'h0};
    tbl[4]  = '{0, 0, 0, 0,      0, 1, 32'h0,   1, 32'h0};
    tbl[5]  = '{0, 0, 0, 0,      0, 0, 32'h0,   1, 32'h0};
    tbl[6]  = '{1, 0, 0, 0,      0, 0, 32'h0,   1, 32'h0};
    tbl[7]  = '{1, 0, 0, 0,      1, 1, 32'h4,   1, 32'h1};
    tbl[8]  = '{0, 1, 0, 0,      1, 1, 32'h5,   1, 32'h2};
    tbl[9]  = '{0, 1, 0, 0,      1, 1, 32'h5,   1, 32'h2};
    tbl[10] = '{0, 1, 0, 0,      1, 1, 32'h5,   1, 32'h2};
    tbl[11] = '{1, 0, 0, 0,      1, 1, 32'h5,   1, 32'h2};
    tbl[12] = '{1, 0, 0, 0,      1, 1, 32'h6,   1, 32'h3};
    tbl[13] = '{1, 0, 0, 0,      1, 1, 32'h7,   1, 32'h4};
    tbl[14] = '{1, 0, 1, 32'h100, 1, 1, 32'h8,  1, 32'h5};
    tbl[15] = '{1, 0, 0, 0,      0, 0, 32'h0,   0, 0};
    tbl[16] = '{1, 0, 0, 0,      1, 1, 32'h100, 0, 0};
    tbl[17] = '{1, 0, 0, 0,      1, 1, 32'h101, 0, 0};
    tbl[18] = '{1, 0, 0, 0,      1, 1, 32'h102, 1, 32'h100};

    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    do_reset(3);

    for (int i = 0; i < 19; i++) begin
      t_drive(tbl[i].rdy, tbl[i].stl, tbl[i].rdr, tbl[i].rpc);
      chk($sformatf("v%0d_stb", i), bus.bus_stb, tbl[i].e_stb);
      chk($sformatf("v%0d_cyc", i), bus.bus_cyc, tbl[i].e_cyc);
      if (tbl[i].e_stb) chk($sformatf("v%0d_addr", i), bus.bus_addr, tbl[i].e_addr);
      chk($sformatf("v%0d_valid", i), instr_valid, tbl[i].e_valid);
      if (tbl[i].e_valid) begin
        chk($sformatf("v%0d_pc", i), instr_pc, tbl[i].e_pc);
        chk($sformatf("v%0d_data", i), instr_data, word_of(tbl[i].e_pc));
      end
      t_finish();
    end

    // Error on address 7: error entry delivered, nothing fetched past it, halt until redirect.
    tick(1, 0, 1, 32'h0);
    err_on = 1'b1; err_addr = 32'h7;
    past7 = 0; seen_err = 0; err_pc = '1;
    for (int i = 0; i < 24; i++) begin
      t_drive(1, 0, 0, 0);
      if (bus.bus_stb === 1'b1 && bus.bus_addr > 32'h7) past7++;
      if (instr_valid === 1'b1 && instr_err === 1'b1) begin
        seen_err = 1;
        err_pc = instr_pc;
      end
      t_finish();
    end
    err_on = 1'b0;
    chk("err_entry_seen", seen_err, 1);
    chk("err_entry_pc", err_pc, 32'h7);
    chk("no_req_past_err", past7, 0);
    t_drive(1, 0, 0, 0);
    chk("halt_stb", bus.bus_stb, 0);
    chk("halt_cyc", bus.bus_cyc, 0);
    chk("halt_valid", instr_valid, 0);
    t_finish();
    tick(1, 0, 1, 32'h40);
    t_drive(1, 0, 0, 0);
    chk("flush_cyc", bus.bus_cyc, 0);
    t_finish();
    t_drive(1, 0, 0, 0);
    chk("resume_stb", bus.bus_stb, 1);
    chk("resume_addr", bus.bus_addr, 32'h40);
    t_finish();

    // Randomized traffic: variable latency, stalls, back-pressure, redirects (some near the
    // address wrap), random errors, and one reset in the middle of activity.
    lat_lo = 1; lat_hi = 3; err_pct = 2;
    for (int i = 0; i < 4000; i++) begin
      logic [31:0] rpc;
      bit rdr;
      if (i == 2000) begin
        do_reset(2);
        t_drive(1, 0, 0, 0);
        chk("post_reset_addr", bus.bus_addr, ResetVec);
        chk("post_reset_stb", bus.bus_stb, 1);
        t_finish();
      end
      rdr = ($urandom_range(99, 0) < 3);
      rpc = ($urandom_range(3, 0) == 0) ? 32'hFFFF_FFFE : $urandom;
      tick(($urandom_range(99, 0) < 70), ($urandom_range(99, 0) < 30), rdr, rpc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
